// File: rtl/bch_encoder.sv
// bch_encoder: systematic BCH(15,7) encoder over GF(16).
// Parity is produced serially by an LFSR dividing by g(x) = 0x1D1.
module bch_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_msg,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [14:0] out_code,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t     state;
  state_t     state_n;
  logic [6:0] msg_reg;
  logic [6:0] msg_n;
  logic [7:0] p;
  logic [7:0] p_n;
  logic [2:0] cnt;
  logic [2:0] cnt_n;
  logic       fb;

  assign in_ready = (state == IDLE) && !rst;

  always_comb begin
    state_n = state;
    msg_n   = msg_reg;
    p_n     = p;
    cnt_n   = cnt;
    fb      = msg_reg[cnt] ^ p[7];
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          msg_n   = in_msg;
          p_n     = 8'h00;
          cnt_n   = 3'd6;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        // MSB-first division step; g(x) minus its x^8 term is 0xD1
        p_n = {p[6:0], 1'b0} ^ (fb ? 8'hD1 : 8'h00);
        if (cnt == 3'd0) begin
          state_n = DONE;
        end else begin
          cnt_n = cnt - 3'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      msg_reg   <= 7'h00;
      p         <= 8'h00;
      cnt       <= 3'd0;
      out_valid <= 1'b0;
      out_code  <= 15'h0000;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      msg_reg   <= msg_n;
      p         <= p_n;
      cnt       <= cnt_n;
      out_valid <= (state_n == DONE);
      busy      <= (state_n != IDLE);
      out_code  <= (state_n == DONE) ? {msg_n, p_n} : 15'h0000;
    end
  end

endmodule

// File: tb/tb_bch_encoder.sv
// tb_bch_encoder: directed table, handshake corner cases and random
// regression with a syndrome-based double-error corrector as receiver.
module tb_bch_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_msg;
  logic        out_valid;
  logic        out_ready;
  logic [14:0] out_code;
  logic        busy;

  always #5 clk = ~clk;

  bch_encoder dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_msg(in_msg),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_code(out_code),
    .busy(busy)
  );

  typedef struct {
    logic [6:0]  msg;
    logic [14:0] code;
  } vec_t;

  vec_t       vecs[6];
  int         nvec = 0;
  int         nbad = 0;
  logic [3:0] alog[15];

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // long division of m(x)*x^8 by g(x)
  function automatic logic [14:0] model(input logic [6:0] m);
    logic [14:0] r;
    r = {m, 8'h00};
    for (int i = 14; i >= 8; i--)
      if (r[i]) r = r ^ (15'h01D1 << (i - 8));
    return {m, r[7:0]};
  endfunction

  function automatic logic [3:0] synd(input logic [14:0] c, input int j);
    logic [3:0] s;
    s = 4'h0;
    for (int i = 0; i < 15; i++)
      if (c[i]) s = s ^ alog[(i * j) % 15];
    return s;
  endfunction

  function automatic logic [14:0] correct(input logic [14:0] r);
    logic [3:0] s1;
    logic [3:0] s3;
    s1 = synd(r, 1);
    s3 = synd(r, 3);
    if (s1 == 4'h0 && s3 == 4'h0) return r;
    for (int i = 0; i < 15; i++)
      if (alog[i] == s1 && alog[(3 * i) % 15] == s3)
        return r ^ (15'h0001 << i);
    for (int i = 0; i < 15; i++)
      for (int j = i + 1; j < 15; j++)
        if ((alog[i] ^ alog[j]) == s1 &&
            (alog[(3 * i) % 15] ^ alog[(3 * j) % 15]) == s3)
          return r ^ (15'h0001 << i) ^ (15'h0001 << j);
    return r;
  endfunction

  task automatic accept(input logic [6:0] m, output bit ok);
    int n;
    n = 0;
    in_msg   = m;
    in_valid = 1'b1;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready;
    if (ok) begin
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_msg   = 7'($urandom);
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic encode(input logic [6:0] m, input int gap,
                        output logic [14:0] code);
    bit ok;
    int lat;
    accept(m, ok);
    check("accept", 32'(ok), 1);
    wait_out(lat);
    check("latency", lat, 8);
    code = out_code;
    for (int k = 0; k < gap; k++) begin
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 1);
      check("hold_code", 32'(out_code), 32'(code));
    end
    take();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [14:0] code;
    logic [14:0] exp_a;
    logic [14:0] exp_b;
    logic [14:0] e;
    logic [6:0]  m;
    logic [3:0]  a;
    bit          ok;
    bit          seen;
    int          lat;
    int          i0;
    int          j0;

    a = 4'h1;
    for (int i = 0; i < 15; i++) begin
      alog[i] = a;
      a = {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
    end

    vecs[0] = '{7'h00, 15'h0000};
    vecs[1] = '{7'h01, 15'h01D1};
    vecs[2] = '{7'h02, 15'h0273};
    vecs[3] = '{7'h03, 15'h03A2};
    vecs[4] = '{7'h04, 15'h04E6};
    vecs[5] = '{7'h7F, 15'h7FFF};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_msg    = 7'h00;
    out_ready = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    check("rst_in_ready2", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_out_code", 32'(out_code), 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 1);

    foreach (vecs[i]) begin
      encode(vecs[i].msg, 0, code);
      check("code", 32'(code), 32'(vecs[i].code));
      check("syndromes", {20'h0, synd(code, 1), synd(code, 2), synd(code, 3)}, 0);
    end

    // backpressure with a second message waiting
    exp_a = 15'h2A00 | 15'(model(7'h2A) & 15'h00FF);
    exp_b = model(7'h55);
    check("model_2a", 32'(exp_a), 32'(model(7'h2A)));
    accept(7'h2A, ok);
    check("bp_accept", 32'(ok), 1);
    wait_out(lat);
    check("bp_latency", lat, 8);
    in_valid = 1'b1;
    in_msg   = 7'h55;
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", 32'(out_valid), 1);
      check("bp_code", 32'(out_code), 32'(exp_a));
      check("bp_in_ready", 32'(in_ready), 0);
      check("bp_busy", 32'(busy), 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_drop_valid", 32'(out_valid), 0);
    check("bp_in_ready_after", 32'(in_ready), 1);
    accept(7'h55, ok);
    check("bp_accept2", 32'(ok), 1);
    wait_out(lat);
    check("bp_latency2", lat, 8);
    check("bp_code2", 32'(out_code), 32'(exp_b));
    take();

    // reset landing on the 4th shift edge
    accept(7'h33, ok);
    check("mr_accept", 32'(ok), 1);
    repeat (3) @(negedge clk);
    check("mr_busy", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    check("mr_no_valid", 32'(seen), 0);
    check("mr_busy_clear", 32'(busy), 0);
    encode(7'h33, 1, code);
    check("mr_code", 32'(code), 32'(model(7'h33)));

    for (int n = 0; n < 2000; n++) begin
      m = 7'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      encode(m, $urandom_range(0, 3), code);
      check("rnd_code", 32'(code), 32'(model(m)));
      check("rnd_synd", {20'h0, synd(code, 1), synd(code, 2), synd(code, 3)}, 0);
      i0 = $urandom_range(0, 14);
      j0 = (i0 + $urandom_range(1, 14)) % 15;
      e  = 15'h0001 << i0;
      if ($urandom_range(0, 1) == 1) e = e | (15'h0001 << j0);
      check("rnd_correct", 32'(correct(code ^ e)), 32'(code));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/bch_encoder.md
# bch_encoder

Systematic BCH(15,7) double-error-correcting encoder over GF(16) (primitive poly x^4+x+1). It is the transmit-side counterpart of the syndrome/error-locator decoder pipeline. The block accepts 7-bit message words over a valid/ready handshake and computes the 8 parity bits serially with an LFSR dividing by g(x) = x^8+x^7+x^6+x^4+1 (0x1D1). It presents the 15-bit codeword on a second valid/ready handshake, and its output feeds the channel/test path whose receiver computes S1, S2 and S3.

## Interface
- Parameters: none. Code (15,7), g(x) = 0x1D1 and the bit ordering are fixed.
- clk    in   1   single clock; all state updates on the rising edge
- rst    in   1   synchronous, active-high reset
- in_valid   in   1   message word valid
- in_ready   out  1   encoder can accept a message; equals (state == IDLE) && !rst
- in_msg     in   7   message; bit i = coefficient of x^(i+8) in c(x)
- out_valid  out  1   codeword valid
- out_ready  in   1   downstream accepts codeword
- out_code   out  15  codeword c(x); bit i = coefficient of x^i; [14:8] = message, [7:0] = parity
- busy       out  1   high in SHIFT or DONE

## Operation
- States: IDLE, SHIFT, DONE.
- **IDLE**
  - in_ready = 1.
  - On in_valid && in_ready: latch in_msg into msg_reg, clear parity p[7:0] to 0, clear bit counter cnt to 6, go to SHIFT.
- **SHIFT**
  - One message bit per cycle, MSB first: b = msg_reg[cnt].
  - fb = b ^ p[7]; p <= {p[6:0],1'b0} ^ (fb ? 8'hD1 : 8'h00).
  - cnt decrements each cycle. The cycle that processes cnt == 0 transitions to DONE.
  - Exactly 7 SHIFT cycles. in_valid is ignored and in_ready = 0.
- **DONE**
  - out_valid = 1, out_code = {msg_reg, p}, held stable until accepted.
  - On out_valid && out_ready: go to IDLE.
  - No new message is accepted in the same cycle.
- Arithmetic: GF(2) only (XOR). No carries, no truncation. p is always exactly 8 bits.
- A bit-parallel combinational reference is allowed in the bench only, not in RTL.

## Timing
- Reset (rst high at an edge):
  - state = IDLE, msg_reg = 0, p = 0, cnt = 0.
  - out_valid = 0, out_code = 0, busy = 0.
  - in_ready = 0 while rst is high and 1 in the first cycle after rst deasserts.
- Reset mid-operation (in SHIFT or DONE) aborts the word: the codeword is never presented and out_valid drops to 0 in the following cycle.
- Latency:
  - Accept at edge E0; SHIFT occupies edges E1..E7.
  - out_valid is high starting after E7, i.e. 8 cycles after acceptance.
- Throughput: with out_ready tied high, one codeword per 9 cycles (accept, 7 shift, 1 DONE).
- Backpressure:
  - out_valid and out_code stay constant while out_ready = 0, for any number of cycles.
  - in_msg changes after acceptance have no effect.
- in_valid during SHIFT or DONE is not consumed. The upstream must hold it until in_ready.
- All outputs are registered except in_ready, which is decoded from state and rst.

## Test plan
- **Reset values and zero message**
  - Stimulus: rst 2 cycles, then in_msg = 7'h00.
  - Required: in_ready = 0 during reset and 1 after; out_code = 15'h0000; out_valid rises exactly 8 cycles after accept.
- **Single-bit messages**
  - in_msg = 7'h01 -> out_code = 15'h01D1.
  - in_msg = 7'h02 -> 15'h0273.
  - in_msg = 7'h03 -> 15'h03A2 (linearity check).
- **All-ones message**
  - in_msg = 7'h7F -> out_code = 15'h7FFF.
  - Required: the receiver-side syndromes of the emitted word (S1, S2, S3) are all 0.
- **Backpressure**
  - Stimulus: out_ready low for 5 cycles in DONE; in_valid held high with a second message.
  - Required: out_code is stable; the second message is accepted only in the cycle after the out handshake; the second codeword is correct.
- **Mid-operation reset**
  - Stimulus: assert rst at the 4th SHIFT cycle.
  - Required: out_valid never asserts for that word; the next message after reset encodes correctly.
- **Random regression**
  - Stimulus: 2000 random messages with random in_valid/out_ready gaps.
  - Required:
    - out_code matches a bench model of m(x)·x^8 + (m(x)·x^8 mod 0x1D1).
    - Every codeword yields zero syndromes in the decoder.
    - Every codeword with 1 or 2 injected bit flips is corrected by the decoder pipeline.
